rom_addr_seq: RTL and testbench
===============================

Name: rom_addr_seq

Overview:
Parametrised ROM address sequencer. It is the next generation of the free-running ROM address counter.
- Generates a read-address stream plus an enable for a downstream ROM.
- Adds programmable base/length, one-shot and loop modes, a downstream stall input, an abort input and completion flags.
- Sits between the control logic and the ROM, feeding the ALU-RAM datapath.

Parameters:
ADDR_W, 4, width of s_addr_ROM and base_addr.
DEPTH, 14, number of valid ROM words; valid addresses are 0..DEPTH-1; DEPTH <= 2**ADDR_W.
LEN_W, 5, width of len; must satisfy 2**LEN_W > DEPTH.

Ports:
CP  in  1  clock; all state changes on the rising edge.
RST  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request to begin a sequence; sampled only in IDLE.
stop  in  1  abort; returns the block to IDLE.
mode  in  1  0 = one-shot, 1 = loop; latched on an accepted start.
base_addr  in  ADDR_W  first address; latched on an accepted start.
len  in  LEN_W  number of words; latched on an accepted start.
ready  in  1  downstream consumed the current address this cycle.
en_ROM  out  1  the current s_addr_ROM is valid for the ROM.
s_addr_ROM  out  ADDR_W  ROM read address.
busy  out  1  high in RUN.
done  out  1  one-cycle pulse at the end of a one-shot sequence.
wrap  out  1  one-cycle pulse when a loop sequence restarts at base.

Behaviour:
- Clock and reset: one clock, CP; RST is asynchronous and active-high.
- Reset values: state = IDLE, s_addr_ROM = 0, en_ROM = 0, busy = 0, done = 0, wrap = 0; internal count = 0; latched mode, base and len = 0.
- States: IDLE, RUN. All outputs are registered.
- IDLE, start = 1 and stop = 0:
  - Latch mode, base and len.
  - Base clamp: base_addr >= DEPTH is replaced by 0.
  - Length rules: len = 0 or len > DEPTH is replaced by DEPTH.
  - Next cycle: state = RUN, s_addr_ROM = base, en_ROM = 1, busy = 1, count = 0. Latency from start to the first valid address is 1 cycle.
- IDLE, no start: s_addr_ROM holds its last value; en_ROM = 0.
- RUN, ready = 0: s_addr_ROM, count and en_ROM hold (stall, any length).
- RUN, ready = 1, count < len-1:
  - count is incremented.
  - s_addr_ROM is incremented; DEPTH-1 wraps to 0, never to DEPTH..2**ADDR_W-1.
- RUN, ready = 1, count = len-1:
  - mode = 0: next cycle state = IDLE, en_ROM = 0, busy = 0, done = 1 for exactly one cycle, s_addr_ROM holds the last address.
  - mode = 1: next cycle s_addr_ROM = base, count = 0, wrap = 1 for one cycle, en_ROM stays 1 with no bubble.
- stop = 1 in any state (priority over start and ready):
  - Next cycle: state = IDLE, en_ROM = 0, busy = 0.
  - No done or wrap pulse is issued; s_addr_ROM holds.
- start while in RUN is ignored; mode, base and len changes mid-run have no effect.
- Simultaneous events:
  - A start in the same cycle the done pulse is asserted is accepted, since the state is already IDLE.
  - A start in the cycle the final ready is accepted (still RUN) is ignored.
- RST asserted mid-sequence: all outputs go to their reset values immediately, without waiting for a CP edge.
- Address arithmetic is done at ADDR_W+1 bits and compared against DEPTH-1 before the wrap; there is no overflow beyond the valid range.

Test Plan (all at defaults):
- Reset/idle: RST pulse, then idle cycles -> en_ROM = 0, s_addr_ROM = 0, busy = 0, no pulses.
- One-shot, no stall: start with base = 3, len = 4, mode = 0, ready = 1 -> s_addr_ROM 3,4,5,6 with en_ROM = 1; then en_ROM = 0, done high for 1 cycle, s_addr_ROM holds 6.
- Wrap at depth and stall: base = 12, len = 5, ready low on the 2nd address for 3 cycles -> sequence 12,13(x4),0,1,2, then done.
- Loop: base = 0, len = 3, mode = 1 -> 0,1,2,0,1,2,... with wrap pulsing each time 0 is re-presented and en_ROM continuously 1; stop -> en_ROM = 0 the next cycle, no done.
- Clamping: base = 15 and len = 0 -> starts at 0 and runs 14 words (0..13), then done; start during RUN is ignored.
- Async reset mid-run: assert RST between CP edges at address 5 -> outputs are at reset values before the next edge; after release, no activity until start.

Source files
------------

// File: rtl/rom_addr_seq.sv
// ROM address sequencer: walks a programmable window of ROM addresses in one-shot
// or loop mode, honouring downstream stalls and an abort, with done/wrap pulses.
module rom_addr_seq #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 14,
  parameter int LEN_W  = 5
) (
  input  logic              CP,
  input  logic              RST,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              ready,
  output logic              en_ROM,
  output logic [ADDR_W-1:0] s_addr_ROM,
  output logic              busy,
  output logic              done,
  output logic              wrap
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [ADDR_W:0]  DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    count_q, count_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                mode_q, mode_d;
  logic                en_q, en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wrap_q, wrap_d;

  logic [ADDR_W:0]     addrInc;
  logic [ADDR_W-1:0]   addrNext;
  logic [ADDR_W-1:0]   baseClamped;
  logic [LEN_W-1:0]    lenClamped;

  // One extra bit on the increment so the wrap test can never alias past DEPTH-1.
  always_comb begin
    addrInc     = {1'b0, addr_q} + (ADDR_W+1)'(1);
    addrNext    = (addrInc >= DEPTH_X) ? '0 : addrInc[ADDR_W-1:0];
    baseClamped = ({1'b0, base_addr} >= DEPTH_X) ? '0 : base_addr;
    lenClamped  = ((len == '0) || (len > DEPTH_L)) ? DEPTH_L : len;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    len_d   = len_q;
    base_d  = base_q;
    mode_d  = mode_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;

    if (stop) begin
      state_d = IDLE;
      en_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          en_d   = 1'b0;
          busy_d = 1'b0;
          if (start) begin
            mode_d  = mode;
            base_d  = baseClamped;
            len_d   = lenClamped;
            state_d = RUN;
            addr_d  = baseClamped;
            count_d = '0;
            en_d    = 1'b1;
            busy_d  = 1'b1;
          end
        end
        RUN: begin
          if (ready) begin
            if (count_q == len_q - LEN_W'(1)) begin
              if (mode_q) begin
                addr_d  = base_q;
                count_d = '0;
                wrap_d  = 1'b1;
              end else begin
                state_d = IDLE;
                en_d    = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            end else begin
              count_d = count_q + LEN_W'(1);
              addr_d  = addrNext;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      len_q   <= '0;
      base_q  <= '0;
      mode_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      len_q   <= len_d;
      base_q  <= base_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign en_ROM     = en_q;
  assign s_addr_ROM = addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_rom_addr_seq.sv
// Directed bench for rom_addr_seq: hand-computed address/flag sequences for
// one-shot, stall, loop, clamping, abort and asynchronous reset.
module tb_rom_addr_seq;

  logic       CP;
  logic       RST;
  logic       start;
  logic       stop;
  logic       mode;
  logic [3:0] base_addr;
  logic [4:0] len;
  logic       ready;
  logic       en_ROM;
  logic [3:0] s_addr_ROM;
  logic       busy;
  logic       done;
  logic       wrap;

  int checkCount;
  int errorCount;

  rom_addr_seq #(.ADDR_W(4), .DEPTH(14), .LEN_W(5)) dut (
    .CP         (CP),
    .RST        (RST),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .base_addr  (base_addr),
    .len        (len),
    .ready      (ready),
    .en_ROM     (en_ROM),
    .s_addr_ROM (s_addr_ROM),
    .busy       (busy),
    .done       (done),
    .wrap       (wrap)
  );

  initial begin
    CP = 1'b0;
    forever #5 CP = ~CP;
  end

  // Observed/expected are packed as {en, busy, done, wrap, addr[3:0]}.
  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got en/busy/done/wrap/addr=%b/%b/%b/%b/%0d, want %b/%b/%b/%b/%0d",
               tag, observed[7], observed[6], observed[5], observed[4], observed[3:0],
               expected[7], expected[6], expected[5], expected[4], expected[3:0]);
    end
  endtask

  task automatic expectOutputs(input string tag, input logic expEn, input logic [3:0] expAddr,
                               input logic expBusy, input logic expDone, input logic expWrap);
    checkOutput(tag, {en_ROM, busy, done, wrap, s_addr_ROM}, {expEn, expBusy, expDone, expWrap, expAddr});
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic md, input logic [3:0] b, input logic [4:0] l);
    start     = st;
    mode      = md;
    base_addr = b;
    len       = l;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    RST   = 1'b1;
    stop  = 1'b0;
    ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'd0, 5'd0);
    #1;
    expectOutputs("reset", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    RST = 1'b0;
    tick();
    tick();
    expectOutputs("idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // One-shot: 3,4,5,6 then done with address held at 6.
    applyStimulus(1'b1, 1'b0, 4'd3, 5'd4);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 5'd0);
    expectOutputs("oneshot_a0", 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 4; i <= 6; i++) begin
      tick();
      expectOutputs($sformatf("oneshot_a%0d", i - 3), 1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
    end
    tick();
    expectOutputs("oneshot_done", 1'b0, 4'd6, 1'b0, 1'b1, 1'b0);
    tick();
    expectOutputs("oneshot_after", 1'b0, 4'd6, 1'b0, 1'b0, 1'b0);

    // Depth wrap plus stall: 12,13,13,13,13,0,1,2 then done.
    applyStimulus(1'b1, 1'b0, 4'd12, 5'd5);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 5'd0);
    expectOutputs("wrap_a12", 1'b1, 4'd12, 1'b1, 1'b0, 1'b0);
    tick();
    expectOutputs("wrap_a13", 1'b1, 4'd13, 1'b1, 1'b0, 1'b0);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expectOutputs($sformatf("stall_%0d", i), 1'b1, 4'd13, 1'b1, 1'b0, 1'b0);
    end
    ready = 1'b1;
    for (int i = 0; i <= 2; i++) begin
      tick();
      expectOutputs($sformatf("wrap_b%0d", i), 1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
    end
    tick();
    expectOutputs("wrap_done", 1'b0, 4'd2, 1'b0, 1'b1, 1'b0);

    // Loop: 0,1,2,0(wrap),1,2,0(wrap) then stop.
    applyStimulus(1'b1, 1'b1, 4'd0, 5'd3);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd9, 5'd9);
    expectOutputs("loop_first", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      expectOutputs($sformatf("loop_%0d", i), 1'b1, 4'(i % 3), 1'b1, 1'b0, (i % 3) == 0);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    expectOutputs("loop_stop", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    expectOutputs("stop_idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Clamping: base 15 -> 0, len 0 -> 14; mid-run start is ignored.
    applyStimulus(1'b1, 1'b0, 4'd15, 5'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 4'd5, 5'd2);
    expectOutputs("clamp_a0", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i == 13) applyStimulus(1'b0, 1'b0, 4'd0, 5'd0);
      expectOutputs($sformatf("clamp_a%0d", i), 1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
    end
    tick();
    expectOutputs("clamp_done", 1'b0, 4'd13, 1'b0, 1'b1, 1'b0);

    // Start in the done-pulse cycle is accepted.
    applyStimulus(1'b1, 1'b0, 4'd2, 5'd2);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 5'd0);
    expectOutputs("restart_a2", 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    tick();
    expectOutputs("restart_a3", 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
    tick();
    expectOutputs("restart_done", 1'b0, 4'd3, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset between edges while presenting address 5.
    applyStimulus(1'b1, 1'b0, 4'd3, 5'd10);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 5'd0);
    tick();
    tick();
    expectOutputs("areset_pre", 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    expectOutputs("areset_now", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    #1;
    RST = 1'b0;
    tick();
    tick();
    expectOutputs("areset_idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
